// File: rtl/mem_ctrl_pkg.sv
// Shared widths, FSM states, length codes and request-source encoding for the
// byte-serialising memory controller.
package mem_ctrl_pkg;

  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StDone
  } state_e;

  typedef enum logic {
    SrcMem,
    SrcIf
  } src_e;

  localparam logic [2:0] LenB = 3'd1;
  localparam logic [2:0] LenH = 3'd2;
  localparam logic [2:0] LenW = 3'd4;

  // Anything that is not a byte or halfword is handled as a full word.
  function automatic logic [2:0] norm_len(input logic [2:0] len);
    case (len)
      LenB:    return LenB;
      LenH:    return LenH;
      default: return LenW;
    endcase
  endfunction

endpackage

// File: rtl/mem_ext.sv
// Load-data extension: sign- or zero-extends an assembled little-endian word
// according to the access length.
module mem_ext
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DataW
) (
  input  logic [DATA_W-1:0] word,
  input  logic [2:0]        len,
  input  logic              sgn,
  output logic [DATA_W-1:0] ext
);

  always_comb begin
    ext = word;
    case (len)
      LenB:    ext = {{(DATA_W - 8){sgn & word[7]}}, word[7:0]};
      LenH:    ext = {{(DATA_W - 16){sgn & word[15]}}, word[15:0]};
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: serialises MEM loads/stores and IF fetches onto a byte-wide
// synchronous RAM port with one-cycle read latency.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrW,
  parameter int unsigned DATA_W = DataW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_load,
  input  logic              mem_save,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [2:0]        mem_len,
  input  logic              mem_signed,
  output logic              mem_done,
  output logic [DATA_W-1:0] mem_rdata,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_data,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_wr,
  input  logic [7:0]        ram_din
);

  state_e            state_q, state_d;
  src_e              src_q, src_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        len_q, len_d;
  logic              sgn_q, sgn_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] buf_q, buf_d;

  logic              mem_done_q, mem_done_d;
  logic              if_done_q, if_done_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              ram_wr_q, ram_wr_d;

  logic              mem_req;
  logic [2:0]        nxt;
  logic [1:0]        idx;
  logic [1:0]        lane;
  logic [DATA_W-1:0] cap_word;
  logic [DATA_W-1:0] ext_word;

  assign mem_req = mem_load | mem_save;
  assign nxt     = cnt_q + 3'd1;
  assign idx     = nxt[1:0];
  // The byte on ram_din was addressed one cycle earlier, so it lands one lane behind cnt_q.
  assign lane    = cnt_q[1:0] - 2'd1;

  always_comb begin
    cap_word = buf_q;
    cap_word[8*lane +: 8] = ram_din;
  end

  mem_ext #(
    .DATA_W (DATA_W)
  ) u_ext (
    .word (cap_word),
    .len  (len_q),
    .sgn  (sgn_q),
    .ext  (ext_word)
  );

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    sgn_d       = sgn_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    mem_done_d  = 1'b0;
    if_done_d   = 1'b0;
    mem_rdata_d = '0;
    if_data_d   = '0;
    ram_a_d     = '0;
    ram_dout_d  = '0;
    ram_wr_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (mem_req || if_req) begin
          cnt_d = '0;
          buf_d = '0;
          if (mem_req) begin
            src_d   = SrcMem;
            addr_d  = mem_addr;
            len_d   = norm_len(mem_len);
            sgn_d   = mem_signed;
            wdata_d = mem_wdata;
          end else begin
            src_d   = SrcIf;
            addr_d  = if_addr;
            len_d   = LenW;
            sgn_d   = 1'b0;
            wdata_d = '0;
          end
          ram_a_d = addr_d;
          if (mem_req && !mem_load) begin
            state_d    = StWrite;
            ram_dout_d = mem_wdata[7:0];
            ram_wr_d   = 1'b1;
          end else begin
            state_d = StRead;
          end
        end
      end

      StRead: begin
        if (src_q == SrcIf && !if_req) begin
          state_d = StIdle;
          cnt_d   = '0;
          buf_d   = '0;
        end else begin
          cnt_d = nxt;
          if (cnt_q != 3'd0) buf_d = cap_word;
          if (nxt < len_q) ram_a_d = addr_q + ADDR_W'(nxt);
          if (cnt_q == len_q) begin
            state_d = StDone;
            cnt_d   = '0;
            buf_d   = '0;
            if (src_q == SrcMem) begin
              mem_done_d  = 1'b1;
              mem_rdata_d = ext_word;
            end else begin
              if_done_d = 1'b1;
              if_data_d = cap_word;
            end
          end
        end
      end

      StWrite: begin
        if (nxt < len_q) begin
          cnt_d      = nxt;
          ram_a_d    = addr_q + ADDR_W'(nxt);
          ram_dout_d = wdata_q[8*idx +: 8];
          ram_wr_d   = 1'b1;
        end else begin
          state_d    = StDone;
          cnt_d      = '0;
          mem_done_d = 1'b1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      src_q       <= SrcMem;
      cnt_q       <= '0;
      len_q       <= '0;
      sgn_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      mem_done_q  <= 1'b0;
      if_done_q   <= 1'b0;
      mem_rdata_q <= '0;
      if_data_q   <= '0;
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      sgn_q       <= sgn_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      mem_done_q  <= mem_done_d;
      if_done_q   <= if_done_d;
      mem_rdata_q <= mem_rdata_d;
      if_data_q   <= if_data_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
    end
  end

  assign mem_done  = mem_done_q;
  assign if_done   = if_done_q;
  assign mem_rdata = mem_rdata_q;
  assign if_data   = if_data_q;
  assign ram_a     = ram_a_q;
  assign ram_dout  = ram_dout_q;
  assign ram_wr    = ram_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte-array RAM model with one-cycle read
// latency and a queue of expected completions.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_load = 1'b0, mem_save = 1'b0, mem_signed = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0, if_addr = '0;
  logic [2:0]  mem_len = 3'd4;
  logic        if_req = 1'b0;
  logic        mem_done, if_done, ram_wr;
  logic [31:0] mem_rdata, if_data, ram_a;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din = 8'h00;

  always #5 clk = ~clk;

  mem_ctrl #(
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_load   (mem_load),
    .mem_save   (mem_save),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_len    (mem_len),
    .mem_signed (mem_signed),
    .mem_done   (mem_done),
    .mem_rdata  (mem_rdata),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_done    (if_done),
    .if_data    (if_data),
    .ram_a      (ram_a),
    .ram_dout   (ram_dout),
    .ram_wr     (ram_wr),
    .ram_din    (ram_din)
  );

  // RAM model: 1 KiB window, address bits [9:0]; preload port used by the tasks.
  logic [7:0] ram [0:1023] = '{default: 8'h00};
  logic       pl_en = 1'b0;
  logic [9:0] pl_addr = '0;
  logic [7:0] pl_data = '0;

  always @(posedge clk) begin
    ram_din <= ram[ram_a[9:0]];
    if (ram_wr) ram[ram_a[9:0]] <= ram_dout;
    if (pl_en) ram[pl_addr] <= pl_data;
  end

  int n_mem_done = 0;
  int n_if_done = 0;
  always @(negedge clk) begin
    if (mem_done) n_mem_done <= n_mem_done + 1;
    if (if_done) n_if_done <= n_if_done + 1;
  end

  typedef struct packed {
    logic        src;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] tr_a   [0:31];
  logic        tr_wr  [0:31];
  logic [7:0]  tr_dout[0:31];

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a[9:0]; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Waits for the selected done pulse, tracing the RAM port per cycle after the accept edge.
  task automatic await_done(input bit want_if, output int cyc, output bit got);
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc < 32) begin
        tr_a[cyc] = ram_a; tr_wr[cyc] = ram_wr; tr_dout[cyc] = ram_dout;
      end
      got = want_if ? if_done : mem_done;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    mem_load = 1'b1; mem_addr = 32'h100; mem_len = 3'd1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({mem_done, if_done, ram_wr, ram_dout, ram_a, mem_rdata, if_data} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: done=%b/%b wr=%b dout=%h a=%h rdata=%h idata=%h, want all 0",
               mem_done, if_done, ram_wr, ram_dout, ram_a, mem_rdata, if_data);
    end
    mem_load = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (ram_a !== 32'h0 || ram_wr !== 1'b0 || mem_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_idle: a=%h wr=%b done=%b, want 0/0/0", ram_a, ram_wr, mem_done);
    end
  endtask

  task automatic test_byte_load();
    int cyc; bit got;
    poke(32'h100, 8'h80);
    for (int s = 1; s >= 0; s--) begin
      exp_q.push_back('{src: 1'b0, data: (s == 1) ? 32'hFFFF_FF80 : 32'h0000_0080, cyc: 3});
      mem_load = 1'b1; mem_addr = 32'h100; mem_len = 3'd1; mem_signed = (s == 1);
      await_done(1'b0, cyc, got);
      e = exp_q.pop_front();
      tests++;
      if (!got || mem_rdata !== e.data || cyc != e.cyc) begin
        fails++;
        $display("FAIL byte_load_s%0d: data=%h cycle=%0d got=%0d, want data=%h cycle=%0d",
                 s, mem_rdata, cyc, got, e.data, e.cyc);
      end
      tests++;
      if (tr_a[1] !== 32'h100 || tr_a[2] !== 32'h0 || tr_wr[1] !== 1'b0) begin
        fails++;
        $display("FAIL byte_load_addr: a1=%h a2=%h wr1=%b, want 100/0/0", tr_a[1], tr_a[2], tr_wr[1]);
      end
      mem_load = 1'b0;
      @(posedge clk); #1;
      tests++;
      if (mem_done !== 1'b0) begin
        fails++;
        $display("FAIL done_pulse_width: mem_done=%b one cycle later, want 0", mem_done);
      end
    end
  endtask

  task automatic test_word_store();
    int cyc; bit got;
    logic [31:0] wd;
    wd = 32'hDEAD_BEEF;
    exp_q.push_back('{src: 1'b0, data: 32'h0, cyc: 5});
    mem_save = 1'b1; mem_addr = 32'h200; mem_wdata = wd; mem_len = 3'd4;
    await_done(1'b0, cyc, got);
    e = exp_q.pop_front();
    tests++;
    if (!got || mem_rdata !== e.data || cyc != e.cyc) begin
      fails++;
      $display("FAIL store_done: data=%h cycle=%0d got=%0d, want data=%h cycle=%0d",
               mem_rdata, cyc, got, e.data, e.cyc);
    end
    mem_save = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (tr_a[k+1] !== 32'h200 + k || tr_wr[k+1] !== 1'b1 || tr_dout[k+1] !== wd[8*k +: 8]) begin
        fails++;
        $display("FAIL store_byte%0d: a=%h wr=%b dout=%h, want a=%h wr=1 dout=%h",
                 k, tr_a[k+1], tr_wr[k+1], tr_dout[k+1], 32'h200 + k, wd[8*k +: 8]);
      end
    end
    tests++;
    if (tr_wr[5] !== 1'b0 || tr_a[5] !== 32'h0) begin
      fails++;
      $display("FAIL store_done_port: wr=%b a=%h in done cycle, want 0/0", tr_wr[5], tr_a[5]);
    end
    @(posedge clk); #1;
    tests++;
    if ({ram[10'h203], ram[10'h202], ram[10'h201], ram[10'h200]} !== wd) begin
      fails++;
      $display("FAIL store_ram: ram=%h, want %h",
               {ram[10'h203], ram[10'h202], ram[10'h201], ram[10'h200]}, wd);
    end
    // Word load back, then len=3 which must behave as a word.
    for (int l = 4; l >= 3; l--) begin
      exp_q.push_back('{src: 1'b0, data: wd, cyc: 6});
      mem_load = 1'b1; mem_addr = 32'h200; mem_len = 3'(l); mem_signed = 1'b0;
      await_done(1'b0, cyc, got);
      e = exp_q.pop_front();
      tests++;
      if (!got || mem_rdata !== e.data || cyc != e.cyc) begin
        fails++;
        $display("FAIL word_load_len%0d: data=%h cycle=%0d got=%0d, want data=%h cycle=%0d",
                 l, mem_rdata, cyc, got, e.data, e.cyc);
      end
      mem_load = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_arbitration();
    int cyc, mem_c, if_c;
    poke(32'h0, 8'h13); poke(32'h1, 8'h00); poke(32'h2, 8'h00); poke(32'h3, 8'h00);
    exp_q.push_back('{src: 1'b0, data: 32'hDEAD_BEEF, cyc: 6});
    exp_q.push_back('{src: 1'b1, data: 32'h0000_0013, cyc: 13});
    mem_load = 1'b1; mem_addr = 32'h200; mem_len = 3'd4; mem_signed = 1'b0;
    if_req = 1'b1; if_addr = 32'h0;
    cyc = 0; mem_c = 0; if_c = 0;
    while ((mem_c == 0 || if_c == 0) && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (mem_done || if_done) begin
        e = exp_q.size() > 0 ? exp_q.pop_front() : '{src: 1'b0, data: 32'hx, cyc: -1};
        tests++;
        if (if_done !== e.src || (if_done ? if_data : mem_rdata) !== e.data || cyc != e.cyc) begin
          fails++;
          $display("FAIL arb_order: if_done=%b data=%h cycle=%0d, want src=%b data=%h cycle=%0d",
                   if_done, if_done ? if_data : mem_rdata, cyc, e.src, e.data, e.cyc);
        end
        if (mem_done) begin mem_c = cyc; mem_load = 1'b0; end
        if (if_done) begin if_c = cyc; if_req = 1'b0; end
      end
    end
    tests++;
    if (mem_c == 0 || if_c == 0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL arb_timeout: mem_done cycle=%0d if_done cycle=%0d left=%0d, want 6/13/0",
               mem_c, if_c, exp_q.size());
      exp_q.delete();
      mem_load = 1'b0; if_req = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_if_abort();
    int cyc, n0; bit got;
    if_req = 1'b1; if_addr = 32'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++;
    if (ram_a !== 32'h1) begin
      fails++;
      $display("FAIL fetch_cycle2_addr: a=%h, want 00000001", ram_a);
    end
    if_req = 1'b0;
    n0 = n_if_done;
    @(posedge clk); #1;
    tests++;
    if (ram_a !== 32'h0 || if_done !== 1'b0) begin
      fails++;
      $display("FAIL abort_port: a=%h if_done=%b, want 0/0", ram_a, if_done);
    end
    repeat (4) @(posedge clk);
    #1;
    tests++;
    if (n_if_done != n0 || ram_a !== 32'h0) begin
      fails++;
      $display("FAIL abort_no_done: pulses=%0d a=%h, want %0d/0", n_if_done, ram_a, n0);
    end
    exp_q.push_back('{src: 1'b1, data: 32'h0000_0013, cyc: 6});
    if_req = 1'b1; if_addr = 32'h0;
    await_done(1'b1, cyc, got);
    e = exp_q.pop_front();
    tests++;
    if (!got || if_data !== e.data || cyc != e.cyc) begin
      fails++;
      $display("FAIL refetch: data=%h cycle=%0d got=%0d, want data=%h cycle=%0d",
               if_data, cyc, got, e.data, e.cyc);
    end
    if_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_store();
    int cyc, n0; bit got;
    mem_save = 1'b1; mem_addr = 32'h300; mem_wdata = 32'h1122_3344; mem_len = 3'd4;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n0 = n_mem_done;
    rst = 1'b0;
    #1;
    tests++;
    if (ram_wr !== 1'b0 || ram_a !== 32'h0 || ram_dout !== 8'h0) begin
      fails++;
      $display("FAIL async_reset: wr=%b a=%h dout=%h, want 0/0/0", ram_wr, ram_a, ram_dout);
    end
    mem_save = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (ram[10'h300] !== 8'h44 || ram[10'h301] !== 8'h00 || n_mem_done != n0) begin
      fails++;
      $display("FAIL partial_store: ram300=%h ram301=%h pulses=%0d, want 44/00/%0d",
               ram[10'h300], ram[10'h301], n_mem_done, n0);
    end
    exp_q.push_back('{src: 1'b0, data: 32'h0, cyc: 5});
    mem_save = 1'b1;
    await_done(1'b0, cyc, got);
    e = exp_q.pop_front();
    tests++;
    if (!got || cyc != e.cyc) begin
      fails++;
      $display("FAIL repeat_store: cycle=%0d got=%0d, want cycle=%0d", cyc, got, e.cyc);
    end
    mem_save = 1'b0;
    @(posedge clk); #1;
    tests++;
    if ({ram[10'h303], ram[10'h302], ram[10'h301], ram[10'h300]} !== 32'h1122_3344) begin
      fails++;
      $display("FAIL repeat_store_ram: ram=%h, want 11223344",
               {ram[10'h303], ram[10'h302], ram[10'h301], ram[10'h300]});
    end
  endtask

  task automatic test_half_wrap();
    int cyc; bit got;
    poke(32'hFFFF_FFFF, 8'h34);
    poke(32'h0, 8'h92);
    exp_q.push_back('{src: 1'b0, data: 32'hFFFF_9234, cyc: 4});
    mem_load = 1'b1; mem_addr = 32'hFFFF_FFFF; mem_len = 3'd2; mem_signed = 1'b1;
    await_done(1'b0, cyc, got);
    e = exp_q.pop_front();
    tests++;
    if (!got || mem_rdata !== e.data || cyc != e.cyc) begin
      fails++;
      $display("FAIL half_wrap: data=%h cycle=%0d got=%0d, want data=%h cycle=%0d",
               mem_rdata, cyc, got, e.data, e.cyc);
    end
    tests++;
    if (tr_a[1] !== 32'hFFFF_FFFF || tr_a[2] !== 32'h0) begin
      fails++;
      $display("FAIL half_wrap_addr: a1=%h a2=%h, want ffffffff/00000000", tr_a[1], tr_a[2]);
    end
    mem_load = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_byte_load();
    test_word_store();
    test_arbitration();
    test_if_abort();
    test_reset_mid_store();
    test_half_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
